// File: rtl/iob_eth_mii_rx_front.sv
// iob_eth_mii_rx_front
// Front end between the PHY MII receive pins and the RX byte-assembly/CRC
// stage. Registers the raw MII inputs, qualifies the preamble, and forwards
// each good frame as a continuous nibble stream that starts with 0x5, 0xD
// (the SFD byte, low nibble first). Bad frames are aborted with rx_err_o.
// Saturating statistics are kept for good frames, aborted frames and
// false-carrier events.
//
// Ports
//   RX_CLK           MII receive clock, all logic on its rising edge
//   rst              synchronous active-high reset
//   phy_rxd[3:0]     MII RXD from the PHY
//   phy_rxdv         MII RX_DV from the PHY
//   phy_rxer         MII RX_ER from the PHY
//   cnt_clr          synchronous clear of all statistics counters
//   rx_data_o[3:0]   nibble to the RX stage
//   rx_dv_o          nibble valid to the RX stage
//   rx_err_o         frame abort indication to the RX stage
//   frame_end_o      one-cycle pulse on a good frame end
//   dribble_o        with frame_end_o: odd nibble count after SFD
//   frames_ok_o      good frames (saturating)
//   frames_err_o     aborted frames (saturating)
//   false_carrier_o  false-carrier events (saturating)
module iob_eth_mii_rx_front #(
  parameter int MAX_NIBBLES = 3044,
  parameter int PRE_MIN     = 2,
  parameter int CNT_W       = 16
) (
  input  logic             RX_CLK,
  input  logic             rst,
  input  logic [3:0]       phy_rxd,
  input  logic             phy_rxdv,
  input  logic             phy_rxer,
  input  logic             cnt_clr,
  output logic [3:0]       rx_data_o,
  output logic             rx_dv_o,
  output logic             rx_err_o,
  output logic             frame_end_o,
  output logic             dribble_o,
  output logic [CNT_W-1:0] frames_ok_o,
  output logic [CNT_W-1:0] frames_err_o,
  output logic [CNT_W-1:0] false_carrier_o
);

  localparam int NW = $clog2(MAX_NIBBLES + 2);
  localparam int PW = $clog2(PRE_MIN + 1);
  localparam logic [NW-1:0] NIB_MAX = NW'(MAX_NIBBLES);
  localparam logic [PW-1:0] PRE_SAT = PW'(PRE_MIN);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PREAMBLE = 2'd1,
    FRAME    = 2'd2,
    DROP     = 2'd3
  } state_t;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                               input logic inc);
    if (inc && (v != {CNT_W{1'b1}})) begin
      sat_inc = v + CNT_W'(1);
    end else begin
      sat_inc = v;
    end
  endfunction

  logic [3:0]    rxd_q;
  logic          dv_q;
  logic          er_q;
  logic [3:0]    d1;

  state_t        state_r, state_s;
  logic [PW-1:0] pre_cnt_r, pre_cnt_s;
  logic [NW-1:0] nib_cnt_r, nib_cnt_s;
  logic          end_pend_r, end_pend_s;
  logic [3:0]    data_s;
  logic          dv_s;
  logic          err_s;
  logic          inc_err_s;
  logic          inc_fc_s;

  // Input stage plus the one-nibble delay that aligns the stream behind SFD.
  always_ff @(posedge RX_CLK) begin
    if (rst) begin
      rxd_q <= 4'h0;
      dv_q  <= 1'b0;
      er_q  <= 1'b0;
      d1    <= 4'h0;
    end else begin
      rxd_q <= phy_rxd;
      dv_q  <= phy_rxdv;
      er_q  <= phy_rxer;
      d1    <= rxd_q;
    end
  end

  // Next-state and next-output decode of the receive FSM.
  always_comb begin
    state_s    = state_r;
    pre_cnt_s  = pre_cnt_r;
    nib_cnt_s  = nib_cnt_r;
    end_pend_s = 1'b0;
    data_s     = rx_data_o;
    dv_s       = 1'b0;
    err_s      = rx_err_o;
    inc_err_s  = 1'b0;
    inc_fc_s   = 1'b0;
    case (state_r)
      IDLE: begin
        err_s = 1'b0;
        if (dv_q) begin
          if ((rxd_q == 4'h5) && !er_q) begin
            state_s   = PREAMBLE;
            pre_cnt_s = PW'(1);
          end else begin
            state_s   = DROP;
            inc_err_s = 1'b1;
          end
        end else if (er_q && (rxd_q == 4'hE)) begin
          inc_fc_s = 1'b1;
        end else begin
          state_s = IDLE;
        end
      end
      PREAMBLE: begin
        if (!dv_q) begin
          state_s = IDLE;
        end else if (er_q) begin
          state_s   = DROP;
          inc_err_s = 1'b1;
        end else if (rxd_q == 4'h5) begin
          if (pre_cnt_r < PRE_SAT) begin
            pre_cnt_s = pre_cnt_r + PW'(1);
          end else begin
            pre_cnt_s = pre_cnt_r;
          end
        end else if ((rxd_q == 4'hD) && (pre_cnt_r >= PRE_SAT)) begin
          // SFD: emit its low nibble now; d1 holds 0xD for the next cycle.
          data_s    = 4'h5;
          dv_s      = 1'b1;
          nib_cnt_s = '0;
          state_s   = FRAME;
        end else begin
          state_s   = DROP;
          inc_err_s = 1'b1;
        end
      end
      FRAME: begin
        // A further nibble once MAX_NIBBLES are in is handled like RX_ER.
        if (er_q || (dv_q && (nib_cnt_r == NIB_MAX))) begin
          err_s     = 1'b1;
          inc_err_s = 1'b1;
          state_s   = DROP;
        end else if (dv_q) begin
          data_s    = d1;
          dv_s      = 1'b1;
          nib_cnt_s = nib_cnt_r + NW'(1);
        end else begin
          // Flush the last delayed nibble; frame_end follows next cycle.
          data_s     = d1;
          dv_s       = 1'b1;
          end_pend_s = 1'b1;
          state_s    = IDLE;
        end
      end
      DROP: begin
        if (!dv_q) begin
          err_s   = 1'b0;
          state_s = IDLE;
        end else begin
          state_s = DROP;
        end
      end
      default: begin
        state_s = IDLE;
        err_s   = 1'b0;
      end
    endcase
  end

  // State, registered outputs and statistics counters.
  always_ff @(posedge RX_CLK) begin
    if (rst) begin
      state_r         <= IDLE;
      pre_cnt_r       <= '0;
      nib_cnt_r       <= '0;
      end_pend_r      <= 1'b0;
      rx_data_o       <= 4'h0;
      rx_dv_o         <= 1'b0;
      rx_err_o        <= 1'b0;
      frame_end_o     <= 1'b0;
      dribble_o       <= 1'b0;
      frames_ok_o     <= '0;
      frames_err_o    <= '0;
      false_carrier_o <= '0;
    end else begin
      state_r     <= state_s;
      pre_cnt_r   <= pre_cnt_s;
      nib_cnt_r   <= nib_cnt_s;
      end_pend_r  <= end_pend_s;
      rx_data_o   <= data_s;
      rx_dv_o     <= dv_s;
      rx_err_o    <= err_s;
      // nib_cnt_r is untouched in IDLE, so it still holds the frame length.
      frame_end_o <= end_pend_r;
      dribble_o   <= end_pend_r & nib_cnt_r[0];
      if (cnt_clr) begin
        frames_ok_o     <= '0;
        frames_err_o    <= '0;
        false_carrier_o <= '0;
      end else begin
        frames_ok_o     <= sat_inc(frames_ok_o, end_pend_r);
        frames_err_o    <= sat_inc(frames_err_o, inc_err_s);
        false_carrier_o <= sat_inc(false_carrier_o, inc_fc_s);
      end
    end
  end

endmodule

// File: tb/tb_iob_eth_mii_rx_front.sv
// Testbench for iob_eth_mii_rx_front. Stimulus tasks describe each frame as
// a list of pin nibbles, derive the expected stream, end/abort events and
// counter values from the frame rules, and queue them; a monitor on the
// falling clock edge pops and compares whatever the DUT presents.
module tb_iob_eth_mii_rx_front;

  localparam int MAX_NIBBLES = 3044;
  localparam int PRE_MIN     = 2;
  localparam int CNT_W       = 16;

  logic             RX_CLK = 1'b0;
  logic             rst = 1'b1;
  logic [3:0]       phy_rxd = 4'h0;
  logic             phy_rxdv = 1'b0;
  logic             phy_rxer = 1'b0;
  logic             cnt_clr = 1'b0;
  logic [3:0]       rx_data_o;
  logic             rx_dv_o;
  logic             rx_err_o;
  logic             frame_end_o;
  logic             dribble_o;
  logic [CNT_W-1:0] frames_ok_o;
  logic [CNT_W-1:0] frames_err_o;
  logic [CNT_W-1:0] false_carrier_o;

  iob_eth_mii_rx_front #(
    .MAX_NIBBLES(MAX_NIBBLES),
    .PRE_MIN    (PRE_MIN),
    .CNT_W      (CNT_W)
  ) dut (
    .RX_CLK         (RX_CLK),
    .rst            (rst),
    .phy_rxd        (phy_rxd),
    .phy_rxdv       (phy_rxdv),
    .phy_rxer       (phy_rxer),
    .cnt_clr        (cnt_clr),
    .rx_data_o      (rx_data_o),
    .rx_dv_o        (rx_dv_o),
    .rx_err_o       (rx_err_o),
    .frame_end_o    (frame_end_o),
    .dribble_o      (dribble_o),
    .frames_ok_o    (frames_ok_o),
    .frames_err_o   (frames_err_o),
    .false_carrier_o(false_carrier_o)
  );

  always #5 RX_CLK = ~RX_CLK;

  int cyc = 0;
  always @(posedge RX_CLK) cyc <= cyc + 1;

  typedef struct { logic [3:0] val; int cyc; } nib_t;
  typedef struct { logic drib; int cyc; } end_t;
  typedef struct { int rise; int fall; } err_t;

  nib_t data_q[$];
  end_t end_q[$];
  err_t err_q[$];

  int n_vec = 0;
  int n_err = 0;
  int exp_ok = 0;
  int exp_errs = 0;
  int exp_fc = 0;

  logic [3:0] pins[$];

  task automatic check(input string name, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: consume expected events as the DUT presents outputs.
  nib_t mon_n;
  end_t mon_e;
  err_t cur_err;
  logic prev_err = 1'b0;
  always @(negedge RX_CLK) begin
    if (!rst) begin
      if (rx_dv_o) begin
        if (data_q.size() == 0) begin
          check("unexpected_dv", 1, 0);
        end else begin
          mon_n = data_q.pop_front();
          check("nibble", rx_data_o, mon_n.val);
          check("nibble_cycle", cyc, mon_n.cyc);
        end
      end
      if (frame_end_o) begin
        if (end_q.size() == 0) begin
          check("unexpected_frame_end", 1, 0);
        end else begin
          mon_e = end_q.pop_front();
          check("dribble", dribble_o, mon_e.drib);
          check("frame_end_cycle", cyc, mon_e.cyc);
        end
      end
      if (rx_err_o && !prev_err) begin
        if (err_q.size() == 0) begin
          check("unexpected_err", 1, 0);
          cur_err.rise = cyc;
          cur_err.fall = -1;
        end else begin
          cur_err = err_q.pop_front();
          check("err_rise_cycle", cyc, cur_err.rise);
        end
      end
      if (!rx_err_o && prev_err) check("err_fall_cycle", cyc, cur_err.fall);
      if (rx_err_o) check("err_dv_exclusive", rx_dv_o, 0);
      prev_err = rx_err_o;
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge RX_CLK); #1;
      phy_rxdv = 1'b0;
      phy_rxer = 1'b0;
      phy_rxd  = 4'($urandom_range(0, 13));
    end
  endtask

  task automatic build_good(input int npre, input int ndata);
    pins.delete();
    repeat (npre) pins.push_back(4'h5);
    pins.push_back(4'hD);
    repeat (ndata) pins.push_back(4'($urandom_range(0, 15)));
  endtask

  // Send pins[] with RX_DV high (RX_ER on index e, -1 for none), then drop
  // RX_DV. Expected results come from the frame rules: every forwarded
  // nibble appears three cycles after its pin cycle.
  task automatic send(input int e);
    int L, c0, s, n, a, cnt;
    bit bad;
    nib_t t;
    end_t te;
    err_t tr;
    L = pins.size();
    @(posedge RX_CLK); #1;
    c0 = cyc;
    bad = 1'b0; s = -1; cnt = 0;
    for (int i = 0; i < L; i++) begin
      if (i == e) begin bad = 1'b1; break; end
      if (pins[i] == 4'h5) cnt++;
      else if (pins[i] == 4'hD && cnt >= PRE_MIN) begin s = i; break; end
      else begin bad = 1'b1; break; end
    end
    if (bad) begin
      exp_errs++;
    end else if (s >= 0) begin
      n = L - 1 - s;
      a = (e > s) ? e : -1;
      if (n > MAX_NIBBLES && (a < 0 || s + 1 + MAX_NIBBLES < a)) a = s + 1 + MAX_NIBBLES;
      if (a < 0) begin
        for (int j = s - 1; j < L; j++) begin
          t.val = pins[j]; t.cyc = c0 + j + 3; data_q.push_back(t);
        end
        te.drib = n[0]; te.cyc = c0 + L + 3; end_q.push_back(te);
        exp_ok++;
      end else begin
        for (int j = s - 1; j <= a - 2; j++) begin
          t.val = pins[j]; t.cyc = c0 + j + 3; data_q.push_back(t);
        end
        tr.rise = c0 + a + 2; tr.fall = c0 + L + 2; err_q.push_back(tr);
        exp_errs++;
      end
    end
    for (int j = 0; j < L; j++) begin
      if (j > 0) begin @(posedge RX_CLK); #1; end
      phy_rxdv = 1'b1;
      phy_rxd  = pins[j];
      phy_rxer = (j == e);
    end
    @(posedge RX_CLK); #1;
    phy_rxdv = 1'b0;
    phy_rxer = 1'b0;
    phy_rxd  = 4'h0;
  endtask

  task automatic check_counters(input string tag);
    idle(8);
    check({tag, "_frames_ok"}, frames_ok_o, exp_ok);
    check({tag, "_frames_err"}, frames_err_o, exp_errs);
    check({tag, "_false_carrier"}, false_carrier_o, exp_fc);
  endtask

  initial begin
    int npre, nd, e, g;
    repeat (3) @(posedge RX_CLK);
    #1;
    check("rst_rx_dv", rx_dv_o, 0);
    check("rst_rx_err", rx_err_o, 0);
    check("rst_rx_data", rx_data_o, 0);
    check("rst_frame_end", frame_end_o, 0);
    check("rst_dribble", dribble_o, 0);
    check("rst_frames_ok", frames_ok_o, 0);
    check("rst_frames_err", frames_err_o, 0);
    check("rst_false_carrier", false_carrier_o, 0);
    rst = 1'b0;
    idle(3);

    // Even and odd length good frames.
    build_good(15, 128); send(-1); idle(5);
    build_good(15, 129); send(-1);
    check_counters("good");

    // RX_ER on data nibble 40.
    build_good(15, 128); send(15 + 40);
    check_counters("rxer");

    // Short preamble before SFD, then a corrupt preamble nibble.
    pins.delete(); pins = '{4'h5, 4'hD, 4'h1, 4'h2, 4'h3, 4'h4}; send(-1); idle(3);
    pins.delete(); pins = '{4'h5, 4'h5, 4'h7, 4'h5, 4'hD, 4'h9}; send(-1);
    check_counters("badpre");

    // One nibble past the length limit, then exactly at the limit.
    build_good(7, MAX_NIBBLES + 1); send(-1); idle(4);
    build_good(7, MAX_NIBBLES); send(-1);
    check_counters("length");

    // False carrier with RX_DV low.
    @(posedge RX_CLK); #1;
    phy_rxdv = 1'b0; phy_rxer = 1'b1; phy_rxd = 4'hE;
    exp_fc++;
    idle(1);
    check_counters("false_carrier");

    // Randomised frames, including back-to-back gaps of one cycle.
    for (int k = 0; k < 24; k++) begin
      npre = $urandom_range(1, 12);
      nd   = $urandom_range(0, 200);
      build_good(npre, nd);
      if ($urandom_range(0, 5) == 0) pins[$urandom_range(0, npre - 1)] = 4'($urandom_range(0, 15));
      e = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, pins.size() - 1)) : -1;
      send(e);
      g = $urandom_range(1, 4);
      if (g > 1) idle(g - 1);
    end
    check_counters("random");

    // Counter clear landing on the same edge as a good frame's count.
    build_good(5, 20); send(-1);
    idle(2);
    cnt_clr = 1'b1;
    @(posedge RX_CLK); #1;
    cnt_clr = 1'b0;
    exp_ok = 0; exp_errs = 0; exp_fc = 0;
    check_counters("clear");

    idle(10);
    check("leftover_nibbles", data_q.size(), 0);
    check("leftover_frame_ends", end_q.size(), 0);
    check("leftover_errors", err_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
